// File: rtl/udma_smi_pkg.sv
// udma_smi_pkg: shared types and constants for the SMI responder.
// Holds the FSM state enum and Clause-22 frame field constants.
package udma_smi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_TA,
    ST_DATA
  } smi_state_e;

  localparam logic [1:0] OP_WR     = 2'b01;
  localparam logic [1:0] OP_RD     = 2'b10;
  localparam logic       SOF_ST    = 1'b1;
  localparam int         HDR_BITS  = 13;
  localparam int         DATA_BITS = 16;

endpackage

// File: rtl/udma_smi_sync.sv
// udma_smi_sync: 2-FF synchroniser, edge register and rising-edge pulse.
// Ports: clk_i, rst_i, d_i (async in), level_o (synced), rise_o (pulse).
module udma_smi_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [2:0] s_q;
  logic       rise_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q    <= '0;
      rise_q <= 1'b0;
    end else begin
      s_q    <= {s_q[1:0], d_i};
      rise_q <= s_q[1] & ~s_q[2];
    end
  end

  // level_o and rise_o both settle on the third edge after the pin
  // changes, so MDIO is sampled in step with the MDC strobe.
  assign level_o = s_q[2];
  assign rise_o  = rise_q;

endmodule

// File: rtl/udma_smi_slave.sv
// udma_smi_slave: Clause-22 MDIO responder with a one-register port.
// Ports: mdc_i/mdi_i pins in, mdo_o/md_oen_o pad out, phy_addr_i,
// reg_addr_o, rd_o/rd_data_i, wr_o/wr_data_o, busy_o, err_o.
module udma_smi_slave #(
  parameter int PREAMBLE_MIN = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mdc_i,
  input  logic        mdi_i,
  output logic        mdo_o,
  output logic        md_oen_o,
  input  logic [4:0]  phy_addr_i,
  output logic [4:0]  reg_addr_o,
  output logic        rd_o,
  input  logic [15:0] rd_data_i,
  output logic        wr_o,
  output logic [15:0] wr_data_o,
  output logic        busy_o,
  output logic        err_o
);
  import udma_smi_pkg::*;

  logic mdc_rise, mdi_s, mdc_lvl, mdi_rise;
  logic sync_unused;

  udma_smi_sync u_mdc (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .d_i     (mdc_i),
    .level_o (mdc_lvl),
    .rise_o  (mdc_rise)
  );

  udma_smi_sync u_mdi (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .d_i     (mdi_i),
    .level_o (mdi_s),
    .rise_o  (mdi_rise)
  );

  assign sync_unused = mdc_lvl ^ mdi_rise;

  smi_state_e  state_q, state_d;
  logic [5:0]  pre_q, pre_d;
  logic [4:0]  bit_q, bit_d;
  logic [15:0] sr_q, sr_d;
  logic        rdop_q, rdop_d;
  logic        load_q;
  logic        mdo_q, mdo_d;
  logic        oen_q, oen_d;
  logic [4:0]  addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [15:0] wdat_q, wdat_d;
  logic        err_q, err_d;
  logic [12:0] hdr;

  // Full header as it stands once the 13th bit is sampled.
  assign hdr = {sr_q[11:0], mdi_s};

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    bit_d   = bit_q;
    rdop_d  = rdop_q;
    mdo_d   = mdo_q;
    oen_d   = oen_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    err_d   = 1'b0;
    // Read data arrives the cycle after rd_o; MDC is far slower,
    // so this never collides with a shift.
    sr_d    = load_q ? rd_data_i : sr_q;
    if (mdc_rise) begin
      unique case (state_q)
        ST_IDLE: begin
          bit_d = '0;
          if (mdi_s) begin
            if (pre_q != 6'(PREAMBLE_MIN)) pre_d = pre_q + 6'd1;
          end else begin
            if (pre_q == 6'(PREAMBLE_MIN)) state_d = ST_HDR;
            pre_d = '0;
          end
        end
        ST_HDR: begin
          sr_d  = {sr_q[14:0], mdi_s};
          bit_d = bit_q + 5'd1;
          if (bit_q == 5'(HDR_BITS - 1)) begin
            bit_d   = '0;
            state_d = ST_IDLE;
            if (hdr[12] != SOF_ST ||
                (hdr[11:10] != OP_WR && hdr[11:10] != OP_RD)) begin
              err_d = 1'b1;
            end else if (hdr[9:5] == phy_addr_i) begin
              addr_d  = hdr[4:0];
              rdop_d  = (hdr[11:10] == OP_RD);
              rd_d    = (hdr[11:10] == OP_RD);
              state_d = ST_TA;
            end
          end
        end
        ST_TA: begin
          bit_d = bit_q + 5'd1;
          if (bit_q[0]) begin
            bit_d   = '0;
            state_d = ST_DATA;
            if (rdop_q) begin
              oen_d = 1'b1;
              mdo_d = 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (rdop_q) begin
            if (bit_q == 5'(DATA_BITS)) begin
              oen_d   = 1'b0;
              bit_d   = '0;
              state_d = ST_IDLE;
            end else begin
              mdo_d = sr_q[15];
              sr_d  = {sr_q[14:0], 1'b0};
              bit_d = bit_q + 5'd1;
            end
          end else begin
            sr_d  = {sr_q[14:0], mdi_s};
            bit_d = bit_q + 5'd1;
            if (bit_q == 5'(DATA_BITS - 1)) begin
              wdat_d  = {sr_q[14:0], mdi_s};
              wr_d    = 1'b1;
              bit_d   = '0;
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      rdop_q  <= 1'b0;
      load_q  <= 1'b0;
      mdo_q   <= 1'b0;
      oen_q   <= 1'b0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      rdop_q  <= rdop_d;
      load_q  <= rd_q;
      mdo_q   <= mdo_d;
      oen_q   <= oen_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdat_q  <= wdat_d;
      err_q   <= err_d;
    end
  end

  assign mdo_o      = mdo_q;
  assign md_oen_o   = oen_q;
  assign reg_addr_o = addr_q;
  assign rd_o       = rd_q;
  assign wr_o       = wr_q;
  assign wr_data_o  = wdat_q;
  assign err_o      = err_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_udma_smi_slave.sv
// tb_udma_smi_slave: frame-level MDIO master and model for the responder.
// Randomised frames plus directed cases, checked against expected pad/strobes.
module tb_udma_smi_slave;

  localparam int PMIN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mdc = 1'b0;
  logic        m_bit = 1'b1;
  logic [4:0]  phy_addr = 5'h01;
  logic [15:0] rd_data = '0;
  logic        mdi;
  logic        mdo, oen, rd, wr, busy, err;
  logic [4:0]  reg_addr;
  logic [15:0] wr_data;

  // Shared pad: responder wins when it drives, else master bit/pull-up.
  assign mdi = oen ? mdo : m_bit;

  udma_smi_slave #(.PREAMBLE_MIN(PMIN)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .mdc_i      (mdc),
    .mdi_i      (mdi),
    .mdo_o      (mdo),
    .md_oen_o   (oen),
    .phy_addr_i (phy_addr),
    .reg_addr_o (reg_addr),
    .rd_o       (rd),
    .rd_data_i  (rd_data),
    .wr_o       (wr),
    .wr_data_o  (wr_data),
    .busy_o     (busy),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic exp_oen = 1'b0, exp_mdo = 1'b0, exp_busy = 1'b0;
  int rd_cnt = 0, wr_cnt = 0, err_cnt = 0;
  logic [4:0]  rd_addr = '0, wr_addr = '0;
  logic [15:0] wr_dat = '0, cap = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Strobe monitor and per-cycle pad/busy comparison.
  always @(negedge clk) begin
    if (rd) begin rd_cnt++; rd_addr = reg_addr; end
    if (wr) begin wr_cnt++; wr_addr = reg_addr; wr_dat = wr_data; end
    if (err) err_cnt++;
    if (chk_en) begin
      chk("md_oen", {31'd0, oen}, {31'd0, exp_oen});
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      if (exp_oen) chk("mdo", {31'd0, mdo}, {31'd0, exp_mdo});
    end
  end

  // One MDC period: 6 clk low (bit presented), 6 clk high.
  task automatic bit_cycle(input logic b, input logic eo,
                           input logic em, input logic eb,
                           input logic capt);
    m_bit = b;
    repeat (6) @(posedge clk);
    #1 mdc = 1'b1;
    chk_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    exp_oen  = eo;
    exp_mdo  = em;
    exp_busy = eb;
    chk_en   = 1'b1;
    if (capt) cap = {cap[14:0], mdo};
    @(posedge clk);
    #1 mdc = 1'b0;
  endtask

  task automatic frame(input int pre, input logic st,
                       input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] rg, input logic [15:0] d,
                       input bit rst_mid);
    logic vs, ok, is_rd, resp, erd, ewr, eerr;
    logic [12:0] hdr;
    int r0, w0, e0;
    bit aborted;
    vs    = (pre >= PMIN);
    is_rd = (op == 2'b10);
    ok    = st && (op == 2'b01 || is_rd);
    eerr  = vs && !ok;
    resp  = vs && ok && (phy == phy_addr);
    erd   = resp && is_rd;
    ewr   = resp && !is_rd;
    hdr   = {st, op, phy, rg};
    rd_data = d;
    r0 = rd_cnt; w0 = wr_cnt; e0 = err_cnt;
    cap = '0;
    aborted = 1'b0;
    repeat (pre) bit_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bit_cycle(1'b0, 1'b0, 1'b0, vs, 1'b0);
    for (int i = 12; i >= 0; i--)
      bit_cycle(hdr[i], 1'b0, 1'b0, (i == 0) ? resp : vs, 1'b0);
    bit_cycle(1'b1, 1'b0, 1'b0, resp, 1'b0);
    bit_cycle(is_rd, erd, 1'b0, resp, 1'b0);
    for (int k = 15; k >= 0; k--) begin
      bit_cycle(is_rd ? 1'b1 : d[k], erd, d[k],
                (k == 0 && ewr) ? 1'b0 : resp, erd);
      if (rst_mid && k == 8) begin
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) begin
      chk_en = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_oen", {31'd0, oen}, 32'd0);
      chk("rst_mdo", {31'd0, mdo}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_addr", {27'd0, reg_addr}, 32'd0);
      rst = 1'b0;
      ewr = 1'b0;
      m_bit = 1'b1;
    end else begin
      // Extra period: read releases the pad; a 0 keeps idle counter at 0.
      bit_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk_en = 1'b0;
    repeat (3) @(posedge clk);
    chk("rd_pulses", rd_cnt - r0, {31'd0, erd});
    chk("wr_pulses", wr_cnt - w0, {31'd0, ewr});
    chk("err_pulses", err_cnt - e0, {31'd0, eerr});
    if (erd) chk("rd_addr", {27'd0, rd_addr}, {27'd0, rg});
    if (ewr) chk("wr_addr", {27'd0, wr_addr}, {27'd0, rg});
    if (ewr) chk("wr_data", {16'd0, wr_dat}, {16'd0, d});
    if (erd && !aborted) chk("rd_serial", {16'd0, cap}, {16'd0, d});
  endtask

  initial begin
    int r;
    logic [1:0] op;
    logic [4:0] phy;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mdo", {31'd0, mdo}, 32'd0);
    chk("reset_oen", {31'd0, oen}, 32'd0);
    chk("reset_addr", {27'd0, reg_addr}, 32'd0);
    chk("reset_rd", {31'd0, rd}, 32'd0);
    chk("reset_wr", {31'd0, wr}, 32'd0);
    chk("reset_wdata", {16'd0, wr_data}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    frame(32, 1'b1, 2'b10, 5'h01, 5'h03, 16'hA5C3, 1'b0);
    chk("lit_rd_serial", {16'd0, cap}, 32'h0000A5C3);
    chk("lit_rd_addr", {27'd0, rd_addr}, 32'h3);
    frame(32, 1'b1, 2'b01, 5'h01, 5'h1F, 16'h1234, 1'b0);
    chk("lit_wr_data", {16'd0, wr_dat}, 32'h1234);
    chk("lit_wr_addr", {27'd0, wr_addr}, 32'h1F);
    frame(32, 1'b1, 2'b10, 5'h02, 5'h05, 16'hFFFF, 1'b0);
    frame(32, 1'b1, 2'b01, 5'h01, 5'h07, 16'h0F0F, 1'b0);
    frame(31, 1'b1, 2'b10, 5'h01, 5'h03, 16'h5555, 1'b0);
    frame(32, 1'b1, 2'b11, 5'h01, 5'h03, 16'h0000, 1'b0);
    frame(32, 1'b1, 2'b10, 5'h01, 5'h0A, 16'h8001, 1'b0);
    frame(32, 1'b1, 2'b01, 5'h01, 5'h0B, 16'hBEEF, 1'b0);
    frame(32, 1'b1, 2'b10, 5'h01, 5'h0C, 16'hC0DE, 1'b1);
    frame(32, 1'b1, 2'b01, 5'h01, 5'h0D, 16'h4321, 1'b0);

    for (int n = 0; n < 24; n++) begin
      phy_addr = 5'($urandom);
      phy = ($urandom_range(0, 3) != 0) ? phy_addr : 5'($urandom);
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'b10 : (r < 8) ? 2'b01 : (r == 8) ? 2'b11 : 2'b00;
      frame(($urandom_range(0, 4) == 0) ? $urandom_range(20, 31)
                                        : $urandom_range(32, 40),
            ($urandom_range(0, 9) != 0), op, phy,
            5'($urandom), 16'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
